usb_dp_tx_sched: RTL and testbench

Line-access scheduler and transmit sequencer in front of the usb_dp pin buffer. It decides when the device may take the bus, enforces the inter-packet turnaround gap, and drives OUT_EN/dataOutP/dataOutN. Once the bus is granted it emits a leading J bit, serialises already NRZI/bit-stuffed data bits at full speed (12 Mb/s on clk48), appends the EOP (SE0 then J) and releases the bus. It sits between the SIE transmit path and usb_dp, and watches dataInP/dataInN plus the receiver's rxActive.

---
 rtl/usb_dp_tx_sched_if.sv | 21 ++
 rtl/usb_dp_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_usb_dp_tx_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_dp_tx_sched_if.sv
// SIE-side transmit handshake for usb_dp_tx_sched.
// master = SIE transmit path, slave = scheduler.
interface usb_dp_tx_sched_if;
  logic txReq;
  logic txGrant;
  logic txBitReq;
  logic txBit;
  logic txLast;
  logic txDone;
  logic busy;

  modport master (
    output txReq, txBit, txLast,
    input  txGrant, txBitReq, txDone, busy
  );

  modport slave (
    input  txReq, txBit, txLast,
    output txGrant, txBitReq, txDone, busy
  );
endinterface

// File: rtl/usb_dp_tx_sched.sv
// USB line-access scheduler and transmit sequencer: gap check, grant,
// leading J, bit serialisation at CLK_PER_BIT clocks per bit, EOP, release.
module usb_dp_tx_sched #(
  parameter int CLK_PER_BIT  = 4,
  parameter int GAP_BITS     = 2,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic             dataInP,
  input  logic             dataInN,
  input  logic             rxActive,
  usb_dp_tx_sched_if.slave sie,
  output logic             OUT_EN,
  output logic             dataOutP,
  output logic             dataOutN
);

  localparam int GAP_CYC = GAP_BITS * CLK_PER_BIT;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam int PW      = $clog2(CLK_PER_BIT);
  localparam int BW      = $clog2(EOP_SE0_BITS + 1);

  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYC);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_PER_BIT - 1);
  localparam logic [PW-1:0] PH_PRE   = PW'(CLK_PER_BIT - 2);
  localparam logic [BW-1:0] SE0_LAST = BW'(EOP_SE0_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE_J,
    S_SEND,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_gap;
  logic [PW-1:0] r_phase;
  logic [BW-1:0] r_bitcnt;
  logic          r_last;
  logic          r_out_en;
  logic          r_dp;
  logic          r_dn;
  logic          r_grant;
  logic          r_bitreq;
  logic          r_done;
  logic          r_busy;

  logic          w_line_idle;
  logic [GW-1:0] w_gap_nxt;
  logic          w_gap_ok;

  // usb_dp echoes J while we drive, so our own drive time never counts
  // as idle: the gap restarts from the release cycle.
  assign w_line_idle = dataInP & ~dataInN & ~rxActive & ~r_out_en;

  always_comb begin
    w_gap_nxt = '0;
    if (w_line_idle)
      w_gap_nxt = (r_gap == GAP_MAX) ? GAP_MAX : r_gap + 1'b1;
  end

  // The current idle cycle counts toward the gap, so a grant lands
  // exactly GAP_CYC idle cycles after the last non-idle one.
  assign w_gap_ok = (w_gap_nxt == GAP_MAX);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) r_gap <= '0;
    else        r_gap <= w_gap_nxt;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_bitcnt <= '0;
      r_last   <= 1'b0;
      r_out_en <= 1'b0;
      r_dp     <= 1'b1;
      r_dn     <= 1'b0;
      r_grant  <= 1'b0;
      r_bitreq <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_grant  <= 1'b0;
      r_bitreq <= 1'b0;
      r_done   <= 1'b0;
      if (r_state == S_IDLE) begin
        r_phase <= '0;
        if (sie.txReq && w_gap_ok && !rxActive) begin
          r_state  <= S_DRIVE_J;
          r_out_en <= 1'b1;
          r_dp     <= 1'b1;
          r_dn     <= 1'b0;
          r_grant  <= 1'b1;
          r_busy   <= 1'b1;
          r_bitcnt <= '0;
        end
      end else begin
        // Every state transition happens at PH_LAST, so the wrap doubles
        // as the phase clear on state entry.
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;

        // Strobes are set one cycle early so they are high in the PH_LAST cycle.
        if (r_phase == PH_PRE) begin
          case (r_state)
            S_DRIVE_J: r_bitreq <= 1'b1;
            S_SEND:    r_bitreq <= ~r_last;
            S_EOP_J:   r_done   <= 1'b1;
            default:   ;
          endcase
        end

        if (r_phase == PH_LAST) begin
          case (r_state)
            S_DRIVE_J: begin
              r_state <= S_SEND;
              r_dp    <= sie.txBit;
              r_dn    <= ~sie.txBit;
              r_last  <= sie.txLast;
            end
            S_SEND: begin
              if (r_last) begin
                r_state  <= S_EOP_SE0;
                r_dp     <= 1'b0;
                r_dn     <= 1'b0;
                r_bitcnt <= '0;
              end else begin
                r_dp   <= sie.txBit;
                r_dn   <= ~sie.txBit;
                r_last <= sie.txLast;
              end
            end
            S_EOP_SE0: begin
              if (r_bitcnt == SE0_LAST) begin
                r_state <= S_EOP_J;
                r_dp    <= 1'b1;
                r_dn    <= 1'b0;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
            S_EOP_J: begin
              r_state  <= S_IDLE;
              r_out_en <= 1'b0;
              r_busy   <= 1'b0;
              r_last   <= 1'b0;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign OUT_EN       = r_out_en;
  assign dataOutP     = r_dp;
  assign dataOutN     = r_dn;
  assign sie.txGrant  = r_grant;
  assign sie.txBitReq = r_bitreq;
  assign sie.txDone   = r_done;
  assign sie.busy     = r_busy;

endmodule

// File: tb/tb_usb_dp_tx_sched.sv
// Bench for usb_dp_tx_sched: packet table plus turnaround, collision,
// back-to-back and mid-transmit reset sequences, line checked per cycle.
module tb_usb_dp_tx_sched;
  localparam int CPB  = 4;
  localparam int GAPC = 8;
  localparam int SE0C = 8;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  logic dataInP = 1'b1;
  logic dataInN = 1'b0;
  logic rxActive = 1'b0;
  logic OUT_EN, dataOutP, dataOutN;

  usb_dp_tx_sched_if sie ();

  usb_dp_tx_sched #(.CLK_PER_BIT(4), .GAP_BITS(2), .EOP_SE0_BITS(2)) dut (
    .clk48    (clk48),
    .rst_n    (rst_n),
    .dataInP  (dataInP),
    .dataInN  (dataInN),
    .rxActive (rxActive),
    .sie      (sie.slave),
    .OUT_EN   (OUT_EN),
    .dataOutP (dataOutP),
    .dataOutN (dataOutN)
  );

  always #10 clk48 = ~clk48;

  typedef struct packed {
    logic p;
    logic n;
    logic g;
    logic d;
  } exp_t;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          exp_on;
    int          exp_lat;
    string       name;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [15:0] pkt = '0;
  int          pkt_len = 0;
  int          pkt_seq = 0;
  int          seen_seq = 0;
  int          bit_idx = 0;
  int          req_cnt = 0;
  int          rel = 0;

  task automatic check(input string name, input int act, input int want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Scoreboard model: expected per-cycle line state for a whole packet.
  task automatic launch(input logic [15:0] bits, input int len);
    exp_t e;
    pkt     = bits;
    pkt_len = len;
    pkt_seq++;
    for (int c = 0; c < CPB; c++) begin
      e = '{1'b1, 1'b0, (c == 0), 1'b0};
      sb.push_back(e);
    end
    for (int i = 0; i < len; i++)
      for (int c = 0; c < CPB; c++) begin
        e = '{bits[i], ~bits[i], 1'b0, 1'b0};
        sb.push_back(e);
      end
    for (int c = 0; c < SE0C; c++) begin
      e = '{1'b0, 1'b0, 1'b0, 1'b0};
      sb.push_back(e);
    end
    for (int c = 0; c < CPB; c++) begin
      e = '{1'b1, 1'b0, 1'b0, (c == CPB - 1)};
      sb.push_back(e);
    end
  endtask

  task automatic wait_grant(input int budget, input string name, output int cyc);
    cyc = 0;
    while (!sie.txGrant && cyc < budget) begin
      @(negedge clk48);
      cyc++;
    end
    if (!sie.txGrant) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no txGrant within %0d cycles", name, budget);
    end
    sie.txReq = 1'b0;
  endtask

  task automatic finish_pkt(input string name, input int exp_on, input int exp_req);
    int on = 1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk48);
      if (!OUT_EN) break;
      on++;
    end
    check({name, " OUT_EN cycles"}, on, exp_on);
    check({name, " txBitReq count"}, req_cnt, exp_req);
    check({name, " scoreboard left"}, sb.size(), 0);
  endtask

  // SIE model and line monitor; sole writer of txBit/txLast.
  always @(negedge clk48) begin
    exp_t e;
    if (!rst_n) begin
      sie.txBit  = 1'b0;
      sie.txLast = 1'b0;
      rel = 0;
    end else begin
      if (pkt_seq != seen_seq) begin
        seen_seq = pkt_seq;
        bit_idx  = 0;
        req_cnt  = 0;
      end
      if (sie.txGrant) rel = 0;
      else rel++;
      if (sie.txBitReq) begin
        check("txBitReq phase", rel % CPB, CPB - 1);
        if (bit_idx < 16) begin
          sie.txBit  = pkt[bit_idx];
          sie.txLast = (bit_idx == pkt_len - 1);
        end
        bit_idx++;
        req_cnt++;
      end
      if (OUT_EN) begin
        if (sb.size() == 0) check("driving with empty scoreboard", 1, 0);
        else begin
          e = sb.pop_front();
          check("line {busy,P,N,grant,done}",
                {sie.busy, dataOutP, dataOutN, sie.txGrant, sie.txDone}, {1'b1, e});
        end
      end else begin
        check("idle {busy,P,N,grant,done,bitreq}",
              {sie.busy, dataOutP, dataOutN, sie.txGrant, sie.txDone, sie.txBitReq}, 6'b010000);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[4];
    int   cyc;
    int   lo;

    tv[0] = '{16'h0001, 1,  20, 1, "min_1bit_J"};
    tv[1] = '{16'h0000, 16, 80, 1, "all_K_16"};
    tv[2] = '{16'h0006, 3,  28, 1, "KJJ_3"};
    tv[3] = '{16'hA5C3, 16, 80, 1, "mix_16"};

    // Reset with request pending and idle line.
    sie.txReq = 1'b1;
    launch(16'h002A, 8);  // K J K J K J K K
    for (int i = 0; i < 5; i++) begin
      @(negedge clk48);
      check("reset {OUT_EN,P,N,grant,busy}",
            {OUT_EN, dataOutP, dataOutN, sie.txGrant, sie.busy}, 5'b01000);
    end
    rst_n = 1'b1;
    wait_grant(40, "reset_grant", cyc);
    check("grant latency after reset", cyc, GAPC);
    finish_pkt("pkt_KJKJKJKK", 48, 8);

    for (int t = 0; t < 4; t++) begin
      repeat (12) @(negedge clk48);
      launch(tv[t].bits, tv[t].len);
      sie.txReq = 1'b1;
      wait_grant(40, tv[t].name, cyc);
      check({tv[t].name, " grant latency"}, cyc, tv[t].exp_lat);
      finish_pkt(tv[t].name, tv[t].exp_on, tv[t].len);
    end

    // Turnaround after receive.
    repeat (12) @(negedge clk48);
    rxActive = 1'b1;
    launch(16'h0001, 1);
    sie.txReq = 1'b1;
    repeat (6) @(negedge clk48);
    rxActive = 1'b0;
    wait_grant(40, "turnaround", cyc);
    check("turnaround grant latency", cyc, GAPC);
    finish_pkt("turnaround", 20, 1);

    // SE0 inside the gap window restarts the count.
    repeat (12) @(negedge clk48);
    rxActive = 1'b1;
    launch(16'h0000, 1);
    sie.txReq = 1'b1;
    repeat (4) @(negedge clk48);
    rxActive = 1'b0;
    repeat (3) @(negedge clk48);
    dataInP = 1'b0;
    @(negedge clk48);
    dataInP = 1'b1;
    wait_grant(40, "se0_restart", cyc);
    check("grant latency after SE0", cyc, GAPC);
    finish_pkt("se0_restart", 20, 1);

    // Collision: request and receive start together.
    repeat (12) @(negedge clk48);
    launch(16'h0001, 1);
    sie.txReq = 1'b1;
    rxActive  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk48);
      check("collision OUT_EN held low", OUT_EN, 0);
    end
    rxActive = 1'b0;
    wait_grant(40, "collision", cyc);
    check("collision grant latency", cyc, GAPC);
    finish_pkt("collision", 20, 1);

    // Back-to-back packets.
    repeat (12) @(negedge clk48);
    launch(16'h002A, 8);
    sie.txReq = 1'b1;
    wait_grant(40, "b2b_first", cyc);
    check("b2b_first grant latency", cyc, 1);
    for (int k = 0; k < 100 && !sie.txDone; k++) @(negedge clk48);
    check("b2b_first txDone seen", sie.txDone, 1);
    check("b2b_first txBitReq count", req_cnt, 8);
    launch(16'h0003, 2);
    sie.txReq = 1'b1;
    lo = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk48);
      if (!OUT_EN) lo++;
      if (sie.txGrant) break;
    end
    check("b2b txGrant seen", sie.txGrant, 1);
    check("b2b OUT_EN low cycles", lo, GAPC);
    sie.txReq = 1'b0;
    finish_pkt("b2b_second", 24, 2);

    // Reset during bit 3 of SEND.
    repeat (12) @(negedge clk48);
    launch(16'h00AA, 8);
    sie.txReq = 1'b1;
    wait_grant(40, "midreset", cyc);
    check("midreset grant latency", cyc, 1);
    repeat (17) @(negedge clk48);
    #2 rst_n = 1'b0;
    #1 check("midreset {OUT_EN,busy,P,N}", {OUT_EN, sie.busy, dataOutP, dataOutN}, 4'b0010);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk48);
      check("in reset {OUT_EN,busy,P,N}", {OUT_EN, sie.busy, dataOutP, dataOutN}, 4'b0010);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk48);
    check("post reset {OUT_EN,busy,grant}", {OUT_EN, sie.busy, sie.txGrant}, 3'b000);
    launch(16'h0001, 1);
    sie.txReq = 1'b1;
    wait_grant(40, "post_reset", cyc);
    check("post reset grant latency", cyc, GAPC - 3);
    finish_pkt("post_reset", 20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
